// File: rtl/chaos_map_pkg.sv
// chaos_map_pkg: shared mode codes, engine states and fixed-point helpers
package chaos_map_pkg;

    localparam logic [1:0] MODE_CUBIC    = 2'd0;
    localparam logic [1:0] MODE_LOGISTIC = 2'd1;
    localparam logic [1:0] MODE_TENT     = 2'd2;
    localparam logic [1:0] MODE_ILLEGAL  = 2'd3;

    typedef enum logic [2:0] {IDLE, MUL1, MUL2, MUL3, EMIT, DONE} state_t;

    // Q2.(w-2) representation of 1.0
    function automatic logic [63:0] fix_one(input int w);
        return 64'd1 << (w - 2);
    endfunction

    // Q2.(w-2) representation of 0.5
    function automatic logic [63:0] fix_half(input int w);
        return fix_one(w) >> 1;
    endfunction

    // Each map enters its iteration at the first multiply it actually needs
    function automatic state_t first_state(input logic [1:0] m);
        return m == MODE_CUBIC ? MUL1 : m == MODE_LOGISTIC ? MUL2 : MUL3;
    endfunction

endpackage

// File: rtl/chaos_map_engine_byte_serializer.sv
// byte_serializer: emits a loaded word LSB-first as a valid/ready byte stream
module byte_serializer
    import chaos_map_pkg::*;
#(
    parameter int W      = 32,
    parameter int NBYTES = (W + 7) / 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] word,
    output logic [7:0]   out_byte,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         last
);

    localparam int CW = NBYTES > 1 ? $clog2(NBYTES) : 1;

    logic [8*NBYTES-1:0] sh;
    logic [CW-1:0]       idx;

    assign out_byte = sh[7:0];
    assign last     = out_valid && out_ready && idx == CW'(NBYTES - 1);

    // Shift one byte out per handshake; valid drops after the final byte
    always_ff @(posedge clk) begin
        if (reset) begin
            sh        <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            sh        <= (8*NBYTES)'(word);
            idx       <= '0;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            sh  <= sh >> 8;
            idx <= idx + CW'(1);
            if (idx == CW'(NBYTES - 1)) out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/chaos_map_engine.sv
// chaos_map_engine: fixed-point cubic/logistic/tent map iterator with byte stream output
module chaos_map_engine
    import chaos_map_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [W-1:0]     u_in,
    input  logic [W-1:0]     x0_in,
    input  logic [CNT_W-1:0] n_iter,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             sat,
    output logic [W-1:0]     x_out,
    output logic             x_valid,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int          FRAC   = W - 2;
    localparam int          NBYTES = (W + 7) / 8;
    localparam logic [W-1:0] ONE   = W'(fix_one(W));
    localparam logic [W-1:0] HALF  = W'(fix_half(W));

    state_t             state;
    logic [1:0]         mode_r;
    logic [W-1:0]       u, x, t, p, s;
    logic [CNT_W-1:0]   remaining;
    logic               free_run, stop_seen, last;
    logic [W-1:0]       op_a, op_b, one_m_x, one_m_t, m_sel, prod_sat;
    logic [2*W-1:0]     prod, prod_sh;
    logic               prod_ovf;

    // Shared multiplier: operands chosen by the current MUL state and map
    always_comb begin
        one_m_x  = x > ONE ? '0 : ONE - x;
        one_m_t  = t > ONE ? '0 : ONE - t;
        m_sel    = x <= HALF ? x : one_m_x;
        op_a     = state == MUL1 ? x : (state == MUL2 || mode_r == MODE_TENT) ? u : p;
        op_b     = (state == MUL1 || state == MUL2) ? x : mode_r == MODE_TENT ? m_sel : s;
        prod     = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
        prod_sh  = prod >> FRAC;
        prod_ovf = |prod_sh[2*W-1:W];
        prod_sat = prod_ovf ? '1 : prod_sh[W-1:0];
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            sat       <= 1'b0;
            x_valid   <= 1'b0;
            x_out     <= '0;
            mode_r    <= MODE_CUBIC;
            u         <= '0;
            x         <= '0;
            t         <= '0;
            p         <= '0;
            s         <= '0;
            remaining <= '0;
            free_run  <= 1'b0;
            stop_seen <= 1'b0;
        end else begin
            done    <= 1'b0;
            err     <= 1'b0;
            x_valid <= 1'b0;
            if (state != IDLE) stop_seen <= stop_seen | stop;
            case (state)
                IDLE: if (start) begin
                    if (mode == MODE_ILLEGAL) err <= 1'b1;
                    else begin
                        u         <= u_in;
                        x         <= x0_in;
                        mode_r    <= mode;
                        remaining <= n_iter;
                        free_run  <= n_iter == '0;
                        sat       <= 1'b0;
                        stop_seen <= 1'b0;
                        busy      <= 1'b1;
                        state     <= first_state(mode);
                    end
                end
                MUL1: begin
                    t     <= prod_sat;
                    sat   <= sat | prod_ovf;
                    state <= MUL2;
                end
                MUL2: begin
                    p     <= prod_sat;
                    s     <= mode_r == MODE_CUBIC ? one_m_t : one_m_x;
                    sat   <= sat | prod_ovf | (mode_r == MODE_CUBIC ? t > ONE : x > ONE);
                    state <= MUL3;
                end
                MUL3: begin
                    x       <= prod_sat;
                    x_out   <= prod_sat;
                    x_valid <= 1'b1;
                    sat     <= sat | prod_ovf | (mode_r == MODE_TENT && x > ONE);
                    state   <= EMIT;
                end
                EMIT: if (last) begin
                    if (!free_run) remaining <= remaining - CNT_W'(1);
                    if (stop_seen || stop || (!free_run && remaining == CNT_W'(1))) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else state <= first_state(mode_r);
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    byte_serializer #(.W(W), .NBYTES(NBYTES)) u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (state == MUL3),
        .word      (prod_sat),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .last      (last)
    );

endmodule

// File: tb/tb_chaos_map_engine.sv
// tb_chaos_map_engine: directed and randomized runs against an arithmetic map model
module tb_chaos_map_engine;

    localparam logic [31:0] ONE = 32'h4000_0000;

    logic        clk = 1'b0, reset, start, stop, out_ready;
    logic [1:0]  mode;
    logic [31:0] u_in, x0_in;
    logic [15:0] n_iter;
    logic        busy, done, err, sat, x_valid, out_valid;
    logic [31:0] x_out;
    logic [7:0]  out_byte;

    int vectors = 0, miscompares = 0;
    bit m_sat;

    always #5 clk = ~clk;

    chaos_map_engine dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
        .u_in(u_in), .x0_in(x0_in), .n_iter(n_iter), .busy(busy), .done(done),
        .err(err), .sat(sat), .x_out(x_out), .x_valid(x_valid),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        r = ({32'd0, a} * {32'd0, b}) >> 30;
        if (r > 64'h0000_0000_FFFF_FFFF) begin
            m_sat = 1'b1;
            return 32'hFFFF_FFFF;
        end
        return r[31:0];
    endfunction

    function automatic logic [31:0] one_minus(input logic [31:0] y);
        if (y > ONE) begin
            m_sat = 1'b1;
            return 32'd0;
        end
        return ONE - y;
    endfunction

    function automatic logic [31:0] next_x(input logic [1:0] md, input logic [31:0] u, input logic [31:0] x);
        if (md == 2'd0) return fmul(fmul(u, x), one_minus(fmul(x, x)));
        if (md == 2'd1) return fmul(fmul(u, x), one_minus(x));
        return fmul(u, x <= ONE / 2 ? x : one_minus(x));
    endfunction

    // rdy: 0 always ready, 1 toggling, 2 toggling with a 20-cycle stall; stop_after>0 pulses stop in MUL2 of that sample
    task automatic run(input string nm, input logic [1:0] md, input logic [31:0] u, input logic [31:0] x0,
                       input int n, input int rdy, input int stop_after);
        logic [31:0] exp_x[$];
        logic [7:0]  exp_b[$];
        logic [31:0] x = x0;
        logic [7:0]  prev_byte = 8'd0;
        int ns, nx = 0, nb = 0, cyc = 0, first_xv = -1;
        bit fin = 0, prev_stall = 0, stopped = 0, exp_sat;
        m_sat = 1'b0;
        ns = n != 0 ? n : stop_after;
        for (int i = 0; i < ns; i++) begin
            x = next_x(md, u, x);
            exp_x.push_back(x);
            for (int k = 0; k < 4; k++) exp_b.push_back(x[8*k +: 8]);
        end
        exp_sat = m_sat;
        mode = md; u_in = u; x0_in = x0; n_iter = 16'(n); out_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({nm, " busy_on"}, busy, 1);
        check({nm, " sat_clr"}, sat, 0);
        while (!fin && cyc < 3000) begin
            out_ready = rdy == 0 ? 1'b1 : (rdy == 2 && cyc >= 8 && cyc < 28) ? 1'b0 : (cyc % 2 == 1);
            if (stop_after > 0 && !stopped && nb == 4 * (stop_after - 1) && nb > 0) begin
                stop = 1'b1;
                stopped = 1;
            end else stop = 1'b0;
            if (x_valid) begin
                if (first_xv < 0) first_xv = cyc;
                if (nx < ns) check({nm, " x_out"}, x_out, exp_x[nx]);
                else check({nm, " extra_sample"}, nx + 1, ns);
                check({nm, " valid_with_x"}, out_valid, 1);
                nx++;
            end
            if (prev_stall) check({nm, " stall_hold"}, {out_valid, out_byte}, {1'b1, prev_byte});
            if (out_valid && out_ready) begin
                if (nb < 4 * ns) check({nm, " byte"}, out_byte, exp_b[nb]);
                else check({nm, " extra_byte"}, nb + 1, 4 * ns);
                nb++;
            end
            prev_stall = out_valid && !out_ready;
            prev_byte  = out_byte;
            if (done) fin = 1;
            cyc++;
            @(negedge clk);
        end
        stop = 1'b0;
        check({nm, " finished"}, fin, 1);
        check({nm, " latency"}, first_xv, md == 2'd0 ? 3 : md == 2'd1 ? 2 : 1);
        check({nm, " samples"}, nx, ns);
        check({nm, " bytes"}, nb, 4 * ns);
        check({nm, " sat"}, sat, exp_sat);
        check({nm, " idle_after"}, {busy, done}, 2'b00);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b1;
        mode = 2'd0; u_in = '0; x0_in = '0; n_iter = '0;
        repeat (2) @(negedge clk);
        check("reset_state", {busy, done, err, sat, x_valid, out_valid, x_out, out_byte}, 46'd0);
        reset = 1'b0;
        @(negedge clk);

        run("cubic", 2'd0, 32'h8000_0000, 32'h2000_0000, 1, 0, 0);
        run("logistic", 2'd1, 32'h8000_0000, 32'h2000_0000, 3, 0, 0);
        run("tent", 2'd2, 32'h8000_0000, 32'h1000_0000, 3, 0, 0);
        run("backpressure", 2'd0, 32'h7000_0000, 32'h1800_0000, 2, 2, 0);
        run("toggle_ready", 2'd2, 32'h7C00_0000, 32'h0F00_0000, 3, 1, 0);
        run("freerun_stop", 2'd1, 32'h8000_0000, 32'h2000_0000, 0, 0, 5);
        run("cubic_sat", 2'd0, 32'h8000_0000, 32'h6000_0000, 1, 0, 0);
        run("sat_cleared", 2'd1, 32'h8000_0000, 32'h2000_0000, 1, 0, 0);

        mode = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("illegal_err", {err, busy}, 2'b10);
        @(negedge clk);
        check("illegal_after", {err, busy}, 2'b00);

        for (int r = 0; r < 5; r++)
            run("random", 2'($urandom_range(0, 2)), $urandom, $urandom_range(0, 32'h4000_0000),
                $urandom_range(1, 3), $urandom_range(0, 2), 0);

        mode = 2'd1; u_in = 32'h8000_0000; x0_in = 32'h2000_0000; n_iter = '0; out_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        check("reset_reach_emit", out_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_emit", {out_valid, busy, x_valid, x_out}, 35'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/chaos_map_engine.md
Name: chaos_map_engine

Overview:
- Parametrised fixed-point chaotic-map iterator; replaces the FPU-based single-map generator.
- Selectable map: cubic, logistic or tent. Configurable word width, with a single shared registered multiplier.
- Runs for a programmable iteration count or free-running.
- Each new sample is serialised LSB-first onto a byte valid/ready stream feeding the UART or a FIFO.

Parameters:
- W, 32, sample/coefficient width; unsigned Q2.(W-2), FRAC=W-2, ONE=1<<FRAC.
- CNT_W, 16, iteration counter width.
- NBYTES, (W+7)/8, bytes emitted per sample (derived; do not override).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  1-cycle pulse; latches mode/u_in/x0_in/n_iter; ignored while busy
- stop  in  1  level or pulse; run ends after current sample fully emitted
- mode  in  2  0=cubic u*x*(1-x^2), 1=logistic u*x*(1-x), 2=tent u*min(x,1-x), 3=illegal
- u_in  in  W  map coefficient, Q2.FRAC
- x0_in  in  W  seed, Q2.FRAC
- n_iter  in  CNT_W  samples to produce; 0 = free-run until stop
- busy  out  1  high from cycle after accepted start until DONE
- done  out  1  1-cycle pulse at run end
- err  out  1  1-cycle pulse when start given with mode=3
- sat  out  1  sticky per run: any clamp occurred; cleared on accepted start
- x_out  out  W  latest sample
- x_valid  out  1  1-cycle pulse when x_out updates
- out_byte  out  8  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready

Behaviour:
- Reset: state IDLE; busy, done, err, sat, x_valid, out_valid = 0; x_out, out_byte = 0; counters = 0. Reset mid-run aborts immediately; no partial byte is held.
- States: IDLE, MUL1, MUL2, MUL3, EMIT, DONE.
- IDLE, start with mode 0..2:
  - latch u, x=x0, mode, remaining=n_iter; clear sat.
  - next state: cubic->MUL1, logistic->MUL2, tent->MUL3.
- IDLE, start with mode=3: err pulse next cycle; stay IDLE.
- MUL1 (cubic only): t <= trunc(x*x).
- MUL2:
  - p <= trunc(u*x).
  - s <= ONE-t (cubic) or ONE-x (logistic).
- MUL3:
  - cubic/logistic: x <= trunc(p*s).
  - tent: x <= trunc(u*m), where m = x if x<=ONE/2 else ONE-x.
- Per-iteration latency: cubic 3 cycles, logistic 2, tent 1 (MULx states).
- Exit of MUL3: x_out=new x and x_valid=1 in the cycle EMIT is entered; out_valid asserts the same cycle with byte 0.
- trunc(a*b) = (a*b)>>FRAC.
- If the truncated product is >= 2^W, saturate to all-ones and set sat.
- Any ONE-y with y>ONE clamps to 0 and sets sat.
- EMIT:
  - byte k = x_out[8k+7:8k], k=0..NBYTES-1; top byte zero-padded.
  - A byte advances only on out_valid&&out_ready.
  - out_byte/out_valid stable while out_ready=0.
- After the last byte handshake:
  - if n_iter!=0: decrement remaining.
  - if stop seen since start, or remaining reaches 0: go to DONE.
  - otherwise start the next iteration at the mode's first MUL state.
- stop is captured into a sticky flag, so a 1-cycle stop pulse anywhere in the run is honoured.
- stop during MULx still completes and emits that sample.
- DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- start asserted in the same cycle as DONE is ignored.
- Counter: no wrap in free-run (not decremented when n_iter=0).

Decomposition:
- Package chaos_map_pkg: mode encoding constants (MODE_CUBIC, MODE_LOGISTIC, MODE_TENT), state enum, ONE/HALF derivation helper.
- Sub-module byte_serializer (W, NBYTES): loads a W-bit word and drives the valid/ready byte stream; reports last-byte-accepted.
- Multiplier stays inline in the engine.

Test Plan:
- Cubic, W=32, u=0x80000000 (2.0), x0=0x20000000 (0.5), n_iter=1 -> x_out=0x30000000 (0.75); bytes 00,00,00,30; done pulse; busy low after.
- Logistic, u=0x80000000, x0=0x20000000, n_iter=3 -> three samples 0x20000000; exactly 12 bytes; sat=0.
- Tent, u=0x80000000, x0=0x10000000, n_iter=3 -> 0x20000000, 0x40000000, 0x00000000; x_valid at 1-cycle compute latency.
- Backpressure: out_ready toggling 1/0 each cycle and held low 20 cycles -> no byte lost or duplicated; out_byte stable while stalled.
- Free-run n_iter=0, stop pulsed mid-MUL2 of sample 5 -> sample 5 fully emitted, then done; no sample 6. Reset asserted mid-EMIT -> out_valid=0 and busy=0 next cycle.
- Error/saturation cases:
  - mode=3 start -> err pulse, busy stays 0.
  - cubic x0=0x60000000 (1.5) -> s clamped, x_out=0, sat=1.
  - sat cleared by the next start.
